// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Ejects owed change as timed 50c/25c/10c coin pulses, exposing the
//            running remainder; rejects amounts not payable with those coins.
//            Optional CHANGE_TALLY_EN adds per-denomination ejection tallies.
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int VAL_W     = 12,
    parameter int PULSE_CYC = 20000000,
    parameter int GAP_CYC   = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] change_in,
    input  logic             change_valid,
    output logic             change_ready,
    input  logic             abort,
    output logic             coin50,
    output logic             coin25,
    output logic             coin10,
    output logic             busy,
    output logic [VAL_W-1:0] remaining,
    output logic             done,
`ifdef CHANGE_TALLY_EN
    output logic [7:0]       tally50,
    output logic [7:0]       tally25,
    output logic [7:0]       tally10,
`endif
    output logic             err
);

    localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_PULSE = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_50   = 2'd1,
        COIN_25   = 2'd2,
        COIN_10   = 2'd3
    } coin_t;

    state_t           state_q;
    coin_t            coin_sel_q;
    coin_t            coin_sel_d;
    logic [CNT_W-1:0] cnt_q;
    logic [VAL_W-1:0] remaining_q;
    logic [VAL_W-1:0] coin_amt;
    logic [VAL_W-1:0] rem_m50;
    logic [VAL_W-1:0] rem_m25;
    logic [VAL_W-1:0] rem_m10;
    logic             abort_q;
    logic             ready_q;
    logic             busy_q;
    logic             coin50_q;
    logic             coin25_q;
    logic             coin10_q;
    logic             done_q;
    logic             err_q;
    logic             pulse_end;

    function automatic logic payable(input logic [VAL_W-1:0] x);
        payable = (x == '0) ||
                  (((x % VAL_W'(5)) == '0) && (x != VAL_W'(5)) && (x != VAL_W'(15)));
    endfunction

    // Largest coin that leaves a payable remainder; a payable non-zero amount always has one.
    always_comb begin
        rem_m50    = remaining_q - VAL_W'(50);
        rem_m25    = remaining_q - VAL_W'(25);
        rem_m10    = remaining_q - VAL_W'(10);
        coin_sel_d = COIN_NONE;
        if ((remaining_q >= VAL_W'(50)) && payable(rem_m50))
            coin_sel_d = COIN_50;
        else if ((remaining_q >= VAL_W'(25)) && payable(rem_m25))
            coin_sel_d = COIN_25;
        else if ((remaining_q >= VAL_W'(10)) && payable(rem_m10))
            coin_sel_d = COIN_10;
    end

    always_comb begin
        coin_amt = '0;
        case (coin_sel_q)
            COIN_50: coin_amt = VAL_W'(50);
            COIN_25: coin_amt = VAL_W'(25);
            COIN_10: coin_amt = VAL_W'(10);
            default: coin_amt = '0;
        endcase
    end

    assign pulse_end = (state_q == S_PULSE) && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            coin_sel_q  <= COIN_NONE;
            cnt_q       <= '0;
            remaining_q <= '0;
            abort_q     <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            coin50_q    <= 1'b0;
            coin25_q    <= 1'b0;
            coin10_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (change_valid && ready_q) begin
                        // err is decided here so it is visible during the CHECK cycle itself.
                        remaining_q <= change_in;
                        err_q       <= !payable(change_in);
                        abort_q     <= 1'b0;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    abort_q <= 1'b0;
                    if (remaining_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else if (!payable(remaining_q)) begin
                        remaining_q <= '0;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        coin_sel_q <= coin_sel_d;
                        coin50_q   <= (coin_sel_d == COIN_50);
                        coin25_q   <= (coin_sel_d == COIN_25);
                        coin10_q   <= (coin_sel_d == COIN_10);
                        cnt_q      <= CNT_W'(PULSE_CYC - 1);
                        state_q    <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (abort)
                        abort_q <= 1'b1;
                    if (cnt_q == '0) begin
                        remaining_q <= remaining_q - coin_amt;
                        coin50_q    <= 1'b0;
                        coin25_q    <= 1'b0;
                        coin10_q    <= 1'b0;
                        cnt_q       <= CNT_W'(GAP_CYC - 1);
                        state_q     <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        if (abort_q || abort) begin
                            remaining_q <= '0;
                            ready_q     <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            state_q <= S_CHECK;
                        end
                    end else begin
                        if (abort)
                            abort_q <= 1'b1;
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CHANGE_TALLY_EN
    logic [7:0] tally50_q;
    logic [7:0] tally25_q;
    logic [7:0] tally10_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tally50_q <= '0;
            tally25_q <= '0;
            tally10_q <= '0;
        end else if (pulse_end) begin
            if ((coin_sel_q == COIN_50) && (tally50_q != 8'hFF))
                tally50_q <= tally50_q + 8'd1;
            if ((coin_sel_q == COIN_25) && (tally25_q != 8'hFF))
                tally25_q <= tally25_q + 8'd1;
            if ((coin_sel_q == COIN_10) && (tally10_q != 8'hFF))
                tally10_q <= tally10_q + 8'd1;
        end
    end

    assign tally50 = tally50_q;
    assign tally25 = tally25_q;
    assign tally10 = tally10_q;
`endif

    assign change_ready = ready_q;
    assign busy         = busy_q;
    assign coin50       = coin50_q;
    assign coin25       = coin25_q;
    assign coin10       = coin10_q;
    assign remaining    = remaining_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser
// Purpose  : Directed self-checking bench for change_dispenser (PULSE_CYC=4,
//            GAP_CYC=2); tally checks compile in with CHANGE_TALLY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

    localparam int VW = 12;
    localparam int PC = 4;
    localparam int GC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [VW-1:0] change_in = '0;
    logic          change_valid = 1'b0;
    logic          abort = 1'b0;
    logic          change_ready, coin50, coin25, coin10, busy, done, err;
    logic [VW-1:0] remaining;
`ifdef CHANGE_TALLY_EN
    logic [7:0]    tally50, tally25, tally10;
`endif

    int checks   = 0;
    int failures = 0;

    // Capture of one dispensing run, sampled on falling edges.
    int   n_pulses, sum_cents, done_cnt, err_cnt, done_cyc, err_cyc, cycles;
    int   p_den [16];
    int   p_len [16];
    int   g_len [16];
    int   rem_dur [16];
    int   rem_aft [16];
    bit   excl_bad, end_ready;
    int   end_rem;

    change_dispenser #(.VAL_W(VW), .PULSE_CYC(PC), .GAP_CYC(GC)) dut (
        .clk          (clk),
        .rst          (rst),
        .change_in    (change_in),
        .change_valid (change_valid),
        .change_ready (change_ready),
        .abort        (abort),
        .coin50       (coin50),
        .coin25       (coin25),
        .coin10       (coin10),
        .busy         (busy),
        .remaining    (remaining),
        .done         (done),
`ifdef CHANGE_TALLY_EN
        .tally50      (tally50),
        .tally25      (tally25),
        .tally10      (tally10),
`endif
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic run_amount(input logic [VW-1:0] amt, input int abort_cyc);
        int prev_coin, cur, gap;
        n_pulses = 0; sum_cents = 0; done_cnt = 0; err_cnt = 0;
        done_cyc = -1; err_cyc = -1; cycles = 0; excl_bad = 0; end_ready = 0; end_rem = -1;
        for (int i = 0; i < 16; i++) begin
            p_den[i] = 0; p_len[i] = 0; g_len[i] = 0; rem_dur[i] = -1; rem_aft[i] = -1;
        end
        prev_coin = 0; gap = 0;
        @(negedge clk);
        change_in = amt; change_valid = 1'b1;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            change_valid = 1'b0; abort = 1'b0;
            cycles = c;
            cur = coin50 ? 50 : coin25 ? 25 : coin10 ? 10 : 0;
            if ((int'(coin50) + int'(coin25) + int'(coin10)) > 1) excl_bad = 1;
            if (done) begin done_cnt++; done_cyc = c; end
            if (err)  begin err_cnt++;  err_cyc = c;  end
            if (cur != 0 && cur != prev_coin) begin
                if (n_pulses > 0 && n_pulses <= 16) g_len[n_pulses-1] = gap;
                if (n_pulses < 16) begin
                    p_den[n_pulses] = cur; p_len[n_pulses] = 1; rem_dur[n_pulses] = int'(remaining);
                end
                n_pulses++; sum_cents += cur; gap = 0;
            end else if (cur != 0) begin
                if (n_pulses <= 16) p_len[n_pulses-1]++;
            end else if (prev_coin != 0) begin
                gap = 1;
                if (n_pulses <= 16) rem_aft[n_pulses-1] = int'(remaining);
            end else begin
                gap++;
            end
            prev_coin = cur;
            if (c == abort_cyc) abort = 1'b1;
            if (change_ready) begin
                end_ready = 1; end_rem = int'(remaining);
                break;
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (change_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", change_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if ({coin50, coin25, coin10, done, err} !== 5'b0) begin failures++; $display("FAIL reset_outs: got %b expected 00000", {coin50, coin25, coin10, done, err}); end
        checks++; if (remaining !== '0) begin failures++; $display("FAIL reset_remaining: got %0d expected 0", remaining); end
        rst = 1'b1;
        @(negedge clk);
        change_in = 12'd85; change_valid = 1'b1;
        @(negedge clk);
        change_valid = 1'b0;
        @(negedge clk);
        checks++; if (coin50 !== 1'b1) begin failures++; $display("FAIL pre_reset_coin50: got %b expected 1", coin50); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({coin50, coin25, coin10} !== 3'b0) begin failures++; $display("FAIL async_reset_coins: got %b expected 000", {coin50, coin25, coin10}); end
        checks++; if (change_ready !== 1'b1) begin failures++; $display("FAIL async_reset_ready: got %b expected 1", change_ready); end
        checks++; if (remaining !== '0) begin failures++; $display("FAIL async_reset_remaining: got %0d expected 0", remaining); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_85;
        int den [3] = '{50, 25, 10};
        int dur [3] = '{85, 35, 10};
        int aft [3] = '{35, 10, 0};
        run_amount(12'd85, 0);
        checks++; if (end_ready !== 1'b1) begin failures++; $display("FAIL c85_complete: got %b expected 1", end_ready); end
        checks++; if (n_pulses != 3) begin failures++; $display("FAIL c85_npulses: got %0d expected 3", n_pulses); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (p_den[i] != den[i]) begin failures++; $display("FAIL c85_coin%0d: got %0d expected %0d", i, p_den[i], den[i]); end
            checks++; if (p_len[i] != PC) begin failures++; $display("FAIL c85_len%0d: got %0d expected %0d", i, p_len[i], PC); end
            checks++; if (rem_dur[i] != dur[i]) begin failures++; $display("FAIL c85_rem_during%0d: got %0d expected %0d", i, rem_dur[i], dur[i]); end
            checks++; if (rem_aft[i] != aft[i]) begin failures++; $display("FAIL c85_rem_after%0d: got %0d expected %0d", i, rem_aft[i], aft[i]); end
        end
        // Coins are low for the GAP cycles plus the following CHECK cycle.
        for (int i = 0; i < 2; i++) begin
            checks++; if (g_len[i] != GC + 1) begin failures++; $display("FAIL c85_gap%0d: got %0d expected %0d", i, g_len[i], GC + 1); end
        end
        checks++; if (done_cnt != 1 || done_cyc != 23) begin failures++; $display("FAIL c85_done: got cnt=%0d cyc=%0d expected cnt=1 cyc=23", done_cnt, done_cyc); end
        checks++; if (err_cnt != 0) begin failures++; $display("FAIL c85_err: got %0d expected 0", err_cnt); end
        checks++; if (excl_bad !== 1'b0) begin failures++; $display("FAIL c85_exclusive: got %b expected 0", excl_bad); end
    endtask

    task automatic test_55;
        int den [4] = '{25, 10, 10, 10};
        int aft [4] = '{30, 20, 10, 0};
        run_amount(12'd55, 0);
        checks++; if (n_pulses != 4) begin failures++; $display("FAIL c55_npulses: got %0d expected 4", n_pulses); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (p_den[i] != den[i]) begin failures++; $display("FAIL c55_coin%0d: got %0d expected %0d", i, p_den[i], den[i]); end
            checks++; if (rem_aft[i] != aft[i]) begin failures++; $display("FAIL c55_rem_after%0d: got %0d expected %0d", i, rem_aft[i], aft[i]); end
        end
        checks++; if (done_cnt != 1 || done_cyc != 30) begin failures++; $display("FAIL c55_done: got cnt=%0d cyc=%0d expected cnt=1 cyc=30", done_cnt, done_cyc); end
    endtask

    task automatic test_unpayable;
        logic [VW-1:0] amts [2] = '{12'd15, 12'd7};
        for (int k = 0; k < 2; k++) begin
            run_amount(amts[k], 0);
            checks++; if (err_cnt != 1 || err_cyc != 1) begin failures++; $display("FAIL bad%0d_err: got cnt=%0d cyc=%0d expected cnt=1 cyc=1", amts[k], err_cnt, err_cyc); end
            checks++; if (n_pulses != 0 || done_cnt != 0) begin failures++; $display("FAIL bad%0d_activity: got pulses=%0d done=%0d expected 0 0", amts[k], n_pulses, done_cnt); end
            checks++; if (end_ready !== 1'b1 || cycles != 2) begin failures++; $display("FAIL bad%0d_idle: got ready=%b cyc=%0d expected ready=1 cyc=2", amts[k], end_ready, cycles); end
            checks++; if (end_rem != 0) begin failures++; $display("FAIL bad%0d_remaining: got %0d expected 0", amts[k], end_rem); end
        end
    endtask

    task automatic test_abort;
        run_amount(12'd100, 3);
        checks++; if (n_pulses != 1 || p_den[0] != 50) begin failures++; $display("FAIL abort_pulses: got n=%0d den=%0d expected n=1 den=50", n_pulses, p_den[0]); end
        checks++; if (p_len[0] != PC) begin failures++; $display("FAIL abort_len: got %0d expected %0d", p_len[0], PC); end
        checks++; if (rem_aft[0] != 50) begin failures++; $display("FAIL abort_rem_gap: got %0d expected 50", rem_aft[0]); end
        checks++; if (end_ready !== 1'b1 || cycles != 8 || end_rem != 0) begin failures++; $display("FAIL abort_idle: got ready=%b cyc=%0d rem=%0d expected 1 8 0", end_ready, cycles, end_rem); end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
    endtask

    task automatic test_zero;
        run_amount(12'd0, 0);
        checks++; if (done_cnt != 1 || done_cyc != 2) begin failures++; $display("FAIL zero_done: got cnt=%0d cyc=%0d expected cnt=1 cyc=2", done_cnt, done_cyc); end
        checks++; if (n_pulses != 0 || err_cnt != 0) begin failures++; $display("FAIL zero_activity: got pulses=%0d err=%0d expected 0 0", n_pulses, err_cnt); end
        checks++; if (cycles != 3) begin failures++; $display("FAIL zero_idle: got cyc=%0d expected 3", cycles); end
    endtask

    task automatic test_max;
        // 4095 = 81 x 50 + 25 + 10 + 10
        run_amount(12'd4095, 0);
        checks++; if (n_pulses != 84 || sum_cents != 4095) begin failures++; $display("FAIL max_coins: got n=%0d sum=%0d expected n=84 sum=4095", n_pulses, sum_cents); end
        checks++; if (done_cnt != 1 || err_cnt != 0 || end_rem != 0) begin failures++; $display("FAIL max_end: got done=%0d err=%0d rem=%0d expected 1 0 0", done_cnt, err_cnt, end_rem); end
        checks++; if (excl_bad !== 1'b0) begin failures++; $display("FAIL max_exclusive: got %b expected 0", excl_bad); end
    endtask

    task automatic test_back_to_back;
        bit fin;
        fin = 0;
        @(negedge clk);
        change_in = 12'd10; change_valid = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) change_in = 12'd20;
            if (c == 9) begin
                checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done: got %b expected 1", done); end
            end
            if (c == 10) begin
                checks++; if (change_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL b2b_idle: got ready=%b busy=%b expected 1 0", change_ready, busy); end
            end
            if (c == 11) begin
                checks++; if (busy !== 1'b1 || remaining !== 12'd20) begin failures++; $display("FAIL b2b_accept: got busy=%b rem=%0d expected 1 20", busy, remaining); end
            end
        end
        change_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (change_ready) begin fin = 1; break; end
        end
        checks++; if (fin !== 1'b1) begin failures++; $display("FAIL b2b_finish: got %b expected 1", fin); end
    endtask

`ifdef CHANGE_TALLY_EN
    task automatic test_tally;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        checks++; if ({tally50, tally25, tally10} !== 24'h0) begin failures++; $display("FAIL tally_reset: got %h expected 000000", {tally50, tally25, tally10}); end
        run_amount(12'd85, 0);
        run_amount(12'd85, 0);
        checks++; if (tally50 !== 8'd2 || tally25 !== 8'd2 || tally10 !== 8'd2) begin failures++; $display("FAIL tally_count: got %0d %0d %0d expected 2 2 2", tally50, tally25, tally10); end
    endtask
`endif

    initial begin
        test_reset;
        test_85;
        test_55;
        test_unpayable;
        test_abort;
        test_zero;
        test_max;
        test_back_to_back;
`ifdef CHANGE_TALLY_EN
        test_tally;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Sits downstream of vending_fsm. Accepts the change amount, in cents, owed after a successful vend.
- Ejects the change as a timed sequence of 50c/25c/10c coin pulses that drive the coin-return solenoids and LEDs.
- Exposes the running remainder so the top level can mux it onto the 12-bit display value while dispensing.
- Refuses amounts that cannot be paid exactly with 10/25/50 coins.

Parameters:
- VAL_W, 12, width of the cents value; matches display_val.
- PULSE_CYC, 20000000, clk cycles each coin output is held high (200 ms at 100 MHz).
- GAP_CYC, 10000000, clk cycles of idle gap between coins (100 ms).

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- change_in  in  VAL_W  change owed, in cents; sampled on accept
- change_valid  in  1  change_in is valid
- change_ready  out  1  block can accept a new amount
- abort  in  1  stop dispensing after the current coin
- coin50  out  1  50c eject pulse
- coin25  out  1  25c eject pulse
- coin10  out  1  10c eject pulse
- busy  out  1  dispensing in progress
- remaining  out  VAL_W  cents still to dispense
- done  out  1  one-cycle pulse when remaining reaches 0 normally
- err  out  1  one-cycle pulse when an amount is rejected as unpayable

Behaviour:
- Reset (rst=0, async): state=IDLE; every output 0 except change_ready=1; counters 0; any in-flight amount is discarded and coin outputs drop immediately.
- States: IDLE, CHECK, PULSE, GAP, DONE.
- IDLE: change_ready=1, busy=0.
  - Accept when change_valid && change_ready: remaining<=change_in, go to CHECK.
  - change_ready=0 in every other state.
- Payable(x): x==0, or (x mod 5 == 0 and x not in {5,15}).
- CHECK (1 cycle, busy=1):
  - remaining==0 -> DONE.
  - !Payable(remaining) -> err=1 for this cycle, remaining<=0, go to IDLE. No coin is ever pulsed.
  - Otherwise select the largest coin c in {50,25,10} with remaining>=c and Payable(remaining-c), then go to PULSE.
  - Examples: 55 -> 25,10,10,10; 65 -> 25,10,10,10,10; 30 -> 10,10,10.
- PULSE:
  - Exactly one selected coin output is high for exactly PULSE_CYC cycles; coin outputs are mutually exclusive.
  - On the last pulse cycle, remaining<=remaining-c, then go to GAP.
- GAP: all coins low for GAP_CYC cycles, then go to CHECK. If abort was seen at any point since the last CHECK, go to IDLE instead, with remaining<=0 and no done.
- DONE: done=1 for one cycle, busy=0 next cycle, go to IDLE.
- abort in IDLE or CHECK is ignored. An abort in PULSE never truncates the pulse.
- busy=1 in CHECK, PULSE and GAP.
- remaining updates only at pulse end, so the display steps down once per coin.
- Width rules:
  - Subtraction never underflows, guaranteed by the selection rule.
  - change_in up to 2^VAL_W-1 is legal; a payable value dispenses its full coin sequence.
- Counters reload on every state entry. A PULSE_CYC or GAP_CYC of 1 is legal (single-cycle pulse or gap).
- change_valid held high across back-to-back amounts: the next amount is accepted on the first IDLE cycle after DONE.

Optional Feature:
- Macro: CHANGE_TALLY_EN.
- When defined:
  - Adds outputs tally50, tally25, tally10 (each 8 bits), counting coins of each denomination ejected since reset.
  - Each increments on the last PULSE cycle of its coin and saturates at 255.
  - Each clears on reset only.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan (bench overrides PULSE_CYC=4, GAP_CYC=2):
- Reset: hold rst=0 mid-PULSE -> coin outputs 0 the same cycle, change_ready=1, remaining=0, busy=0.
- change_in=85, valid 1 cycle -> sequence coin50, coin25, coin10, each high exactly 4 cycles with 2-cycle gaps; remaining 85->35->10->0; done one cycle later; no err.
- change_in=55 -> coin25 followed by three coin10; no coin50 pulse; done asserted.
- change_in=15, and separately 7 -> err pulse of 1 cycle, no coin pulses, back in IDLE with change_ready=1.
- change_in=100 with abort raised during the first coin50 pulse -> that pulse lasts the full 4 cycles, then IDLE; remaining=0; no done; only one coin pulsed.
- change_in=0 -> done 2 cycles after accept, no coins; with CHANGE_TALLY_EN, two 85c runs -> tally50=2, tally25=2, tally10=2.
